ex_muldiv_unit: RTL and testbench

//  Multi-cycle HI/LO arithmetic companion to the EX stage.
//  - Executes MULT/MULTU/DIV/DIVU iteratively and holds the architectural HI/LO registers.
//  - Serves MFHI/MFLO/MTHI/MTLO.
//  - Raises stallreq while an operation is in flight, so the pipeline freezes the issuing instruction in EX.
//  - Width-generic successor to the single-cycle ALU path.

---
 rtl/ex_muldiv_unit_pkg.sv | 40 ++++
 rtl/muldiv_core.sv | 64 ++++++
 rtl/ex_muldiv_unit.sv | 139 +++++++++++++
 tb/tb_ex_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALU op codes,
// FSM state encoding, width defaults and op-classification helpers.
package ex_muldiv_unit_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 6;

    typedef enum logic [3:0] {
        ALU_OP_NOP   = 4'd0,
        ALU_OP_MULT  = 4'd1,
        ALU_OP_MULTU = 4'd2,
        ALU_OP_DIV   = 4'd3,
        ALU_OP_DIVU  = 4'd4,
        ALU_OP_MFHI  = 4'd5,
        ALU_OP_MFLO  = 4'd6,
        ALU_OP_MTHI  = 4'd7,
        ALU_OP_MTLO  = 4'd8
    } aluop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    function automatic logic is_muldiv_op(aluop_t op);
        return (op == ALU_OP_MULT) || (op == ALU_OP_MULTU) ||
               (op == ALU_OP_DIV)  || (op == ALU_OP_DIVU);
    endfunction

    function automatic logic is_div_op(aluop_t op);
        return (op == ALU_OP_DIV) || (op == ALU_OP_DIVU);
    endfunction

    function automatic logic is_signed_op(aluop_t op);
        return (op == ALU_OP_MULT) || (op == ALU_OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply and restoring
// divide sharing one 2*XLEN accumulator, plus the iteration counter.
module muldiv_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    output logic              last,
    output logic [2*XLEN-1:0] res_next
);

    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   mop_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              div_reg;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;

    // Multiply: acc = {partial, multiplier}; add multiplicand into the top half
    // when the current multiplier bit is set, then shift right one place.
    // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract.
    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, (acc_reg[0] ? mop_reg : '0)};
        mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
        div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, mop_reg};
        if (!div_diff[XLEN]) begin
            div_next = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
        end
        res_next = div_reg ? div_next : mul_next;
    end

    assign last = (cnt_reg == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
            mop_reg <= '0;
            cnt_reg <= '0;
            div_reg <= 1'b0;
        end else if (load) begin
            acc_reg <= div_mode ? {{XLEN{1'b0}}, src_a} : {{XLEN{1'b0}}, src_b};
            mop_reg <= div_mode ? src_b : src_a;
            cnt_reg <= '0;
            div_reg <= div_mode;
        end else if (step) begin
            acc_reg <= res_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle HI/LO companion to the EX stage: owns HI/LO, the mul/div FSM,
// the stall request and the MFHI/MFLO/MTHI/MTLO paths.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT,
    parameter bit DIV0_ONES = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            valid_i,
    input  aluop_t          aluop_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    output logic            stallreq,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            done_o
);

    md_state_t       state_reg;
    logic [XLEN-1:0] hi_reg;
    logic [XLEN-1:0] lo_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;

    logic              issue;
    logic              signed_op;
    logic              div_op;
    logic              div_zero;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              core_last;
    logic [2*XLEN-1:0] core_res;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    assign signed_op = is_signed_op(aluop_i);
    assign div_op    = is_div_op(aluop_i);
    assign div_zero  = div_op && (reg2_i == '0);
    assign issue     = (state_reg == ST_IDLE) && valid_i && is_muldiv_op(aluop_i) && !flush_i;
    assign a_mag     = (signed_op && reg1_i[XLEN-1]) ? -reg1_i : reg1_i;
    assign b_mag     = (signed_op && reg2_i[XLEN-1]) ? -reg2_i : reg2_i;

    muldiv_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (issue && !div_zero),
        .step     ((state_reg == ST_MUL) || (state_reg == ST_DIV)),
        .div_mode (div_op),
        .src_a    (a_mag),
        .src_b    (b_mag),
        .last     (core_last),
        .res_next (core_res)
    );

    // Magnitudes were computed unsigned; restore the latched signs here.
    assign prod_fix = neg_q_reg ? -core_res : core_res;
    assign quo_fix  = neg_q_reg ? -core_res[XLEN-1:0] : core_res[XLEN-1:0];
    assign rem_fix  = neg_r_reg ? -core_res[2*XLEN-1:XLEN] : core_res[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            hi_reg    <= '0;
            lo_reg    <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else if (flush_i) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue) begin
                        neg_q_reg <= signed_op && (reg1_i[XLEN-1] ^ reg2_i[XLEN-1]);
                        neg_r_reg <= signed_op && reg1_i[XLEN-1];
                        if (div_zero) begin
                            if (DIV0_ONES) begin
                                hi_reg <= reg1_i;
                                lo_reg <= '1;
                            end
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= div_op ? ST_DIV : ST_MUL;
                        end
                    end else if (valid_i && (aluop_i == ALU_OP_MTHI)) begin
                        hi_reg <= reg1_i;
                    end else if (valid_i && (aluop_i == ALU_OP_MTLO)) begin
                        lo_reg <= reg1_i;
                    end
                end
                ST_MUL: begin
                    if (core_last) begin
                        hi_reg    <= prod_fix[2*XLEN-1:XLEN];
                        lo_reg    <= prod_fix[XLEN-1:0];
                        state_reg <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (core_last) begin
                        hi_reg    <= rem_fix;
                        lo_reg    <= quo_fix;
                        state_reg <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Low in DONE so the frozen instruction advances exactly once.
    assign stallreq = rst && !flush_i &&
                      (issue || (state_reg == ST_MUL) || (state_reg == ST_DIV));

    always_comb begin
        wdata_o = '0;
        if (rst && valid_i) begin
            if (aluop_i == ALU_OP_MFHI) begin
                wdata_o = hi_reg;
            end else if (aluop_i == ALU_OP_MFLO) begin
                wdata_o = lo_reg;
            end
        end
    end

    assign hi_o   = hi_reg;
    assign lo_o   = lo_reg;
    assign busy_o = (state_reg != ST_IDLE);
    assign done_o = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: reference model pushes expected HI/LO
// on issue, compared when done_o pulses; plus stall, MT/MF, flush and reset checks.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            flush_i;
    logic            valid_i;
    aluop_t          aluop_i;
    logic [XLEN-1:0] reg1_i;
    logic [XLEN-1:0] reg2_i;
    logic            stallreq;
    logic [XLEN-1:0] wdata_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;
    logic            busy_o;
    logic            done_o;

    int n_checks;
    int n_errors;
    logic [63:0] sb_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    ex_muldiv_unit #(
        .XLEN      (XLEN),
        .CNT_W     (6),
        .DIV0_ONES (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .aluop_i  (aluop_i),
        .reg1_i   (reg1_i),
        .reg2_i   (reg2_i),
        .stallreq (stallreq),
        .wdata_o  (wdata_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result as {HI, LO}, computed with wide native arithmetic.
    function automatic logic [63:0] model(aluop_t op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (op)
            ALU_OP_MULTU: res = {32'd0, a} * {32'd0, b};
            ALU_OP_MULT:  res = sa * sb;
            ALU_OP_DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            ALU_OP_DIV: begin
                if (b == 0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = {model_hi, model_lo};
        endcase
        return res;
    endfunction

    // Issue one mul/div like a stalled pipeline: hold valid while stallreq is high.
    task automatic run_op(input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                          input int lat);
        logic [63:0] exp;
        int stalls;
        bit got_done;
        @(negedge clk);
        exp = model(op, a, b);
        sb_q.push_back(exp);
        {model_hi, model_lo} = exp;
        valid_i = 1'b1;
        aluop_i = op;
        reg1_i  = a;
        reg2_i  = b;
        stalls   = 0;
        got_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (done_o) begin
                got_done = 1'b1;
                chk("done_lat", 64'(c), 64'(lat));
                if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
                else                  chk("hilo", {hi_o, lo_o}, sb_q.pop_front());
            end
            if (stallreq) stalls++;
            else break;
            @(negedge clk);
        end
        valid_i = 1'b0;
        chk("stall_cycles", 64'(stalls), 64'(lat));
        chk("done_seen", 64'(got_done), 64'd1);
        $display("op %s a=%h b=%h -> hi=%h lo=%h stalls=%0d", op.name(), a, b, hi_o, lo_o, stalls);
    endtask

    task automatic mt_mf(input aluop_t mt, input aluop_t mf, input logic [31:0] d);
        @(negedge clk);
        valid_i = 1'b1;
        aluop_i = mt;
        reg1_i  = d;
        #1;
        chk("mt_nostall", 64'(stallreq), 64'd0);
        @(negedge clk);
        aluop_i = mf;
        reg1_i  = 32'hDEAD_BEEF;
        #1;
        chk("mf_wdata", 64'(wdata_o), 64'(d));
        valid_i = 1'b0;
        #1;
        chk("mf_invalid_zero", 64'(wdata_o), 64'd0);
        if (mt == ALU_OP_MTHI) model_hi = d;
        else                   model_lo = d;
        $display("%s/%s data=%h wdata=%h", mt.name(), mf.name(), d, d);
    endtask

    aluop_t rnd_ops[4] = '{ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU};

    initial begin
        aluop_t op;
        logic [31:0] a, b;
        n_checks = 0;
        n_errors = 0;
        model_hi = '0;
        model_lo = '0;
        rst     = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        aluop_i = ALU_OP_NOP;
        reg1_i  = '0;
        reg2_i  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_stall", 64'(stallreq), 64'd0);
        chk("rst_wdata", 64'(wdata_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(ALU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        chk("multu_hi", 64'(hi_o), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo_o), 64'h0000_0001);
        run_op(ALU_OP_MULT, 32'hFFFF_FFFD, 32'd7, 33);
        run_op(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
        chk("div_lo", 64'(lo_o), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi_o), 64'hFFFF_FFFF);
        run_op(ALU_OP_DIVU, 32'd100, 32'd0, 1);
        chk("div0_lo", 64'(lo_o), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hi_o), 64'd100);
        run_op(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        run_op(ALU_OP_MULT, 32'h8000_0000, 32'h8000_0000, 33);
        run_op(ALU_OP_DIVU, 32'd5, 32'd9, 33);
        run_op(ALU_OP_DIV, 32'd7, 32'hFFFF_FFFE, 33);

        mt_mf(ALU_OP_MTHI, ALU_OP_MFHI, 32'h0000_1234);
        mt_mf(ALU_OP_MTLO, ALU_OP_MFLO, 32'hCAFE_F00D);

        // Flush at iteration 10 of a divide: abort, keep HI/LO, no done pulse.
        @(negedge clk);
        valid_i = 1'b1;
        aluop_i = ALU_OP_DIV;
        reg1_i  = 32'd1000;
        reg2_i  = 32'd7;
        repeat (11) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush_stall_drop", 64'(stallreq), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("flush_busy", 64'(busy_o), 64'd0);
        chk("flush_hilo", {hi_o, lo_o}, {model_hi, model_lo});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_no_done", 64'(done_o), 64'd0);
        end
        $display("flush DIV at iteration 10 hi=%h lo=%h", hi_o, lo_o);

        // Flush in the issue cycle must prevent the start.
        @(negedge clk);
        valid_i = 1'b1;
        aluop_i = ALU_OP_MULT;
        reg1_i  = 32'd3;
        reg2_i  = 32'd4;
        flush_i = 1'b1;
        #1;
        chk("flush_issue_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("flush_issue_busy", 64'(busy_o), 64'd0);
        $display("flush in issue cycle busy=%0d", busy_o);

        for (int i = 0; i < 8; i++) begin
            op = rnd_ops[$urandom_range(0, 3)];
            a  = $urandom;
            b  = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 1000));
            run_op(op, a, b, (is_div_op(op) && b == 0) ? 1 : 33);
        end

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        valid_i = 1'b1;
        aluop_i = ALU_OP_MULTU;
        reg1_i  = 32'h1234_5678;
        reg2_i  = 32'h9ABC_DEF0;
        repeat (5) @(negedge clk);
        valid_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_hi", 64'(hi_o), 64'd0);
        chk("arst_lo", 64'(lo_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_stall", 64'(stallreq), 64'd0);
        chk("arst_wdata", 64'(wdata_o), 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        run_op(ALU_OP_MULTU, 32'd6, 32'd7, 33);
        chk("post_rst_lo", 64'(lo_o), 64'd42);
        chk("post_rst_hi", 64'(hi_o), 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
